// File: rtl/mux8_rr_sched_pkg.sv
// Shared constants for the round-robin scheduler of the 8-bit select mux.
// Requester indices, {s2,s1} select codes and FSM state encoding.
package mux8_rr_sched_pkg;

    localparam int REQ_B = 0;
    localparam int REQ_C = 1;
    localparam int REQ_D = 2;

    localparam logic [1:0] SEL_B = 2'b00;
    localparam logic [1:0] SEL_C = 2'b01;
    localparam logic [1:0] SEL_D = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        HOLD = 2'd2
    } state_e;

    function automatic logic [1:0] sel_of(input logic [1:0] idx);
        logic [1:0] sel;
        sel = SEL_B;
        if (idx == 2'(REQ_C)) sel = SEL_C;
        if (idx == 2'(REQ_D)) sel = SEL_D;
        return sel;
    endfunction

endpackage

// File: rtl/mux8_rr_sched_rr_pick3.sv
// Three-way round-robin picker: search starts just after the last winner.
// Outputs the winner index and its one-hot; one-hot is zero when no request.
import mux8_rr_sched_pkg::*;

module rr_pick3 (
    input  logic [2:0] req_i,
    input  logic [1:0] last_i,
    output logic [1:0] idx_o,
    output logic [2:0] oh_o
);

    function automatic logic [1:0] first3(
        input logic [2:0] r,
        input logic [1:0] a,
        input logic [1:0] b,
        input logic [1:0] c
    );
        logic [1:0] w;
        w = c;
        if (r[b]) w = b;
        if (r[a]) w = a;
        return w;
    endfunction

    localparam logic [1:0] IB = 2'(REQ_B);
    localparam logic [1:0] IC = 2'(REQ_C);
    localparam logic [1:0] ID = 2'(REQ_D);

    always_comb begin
        idx_o = IB;
        oh_o  = 3'b000;
        if (last_i == IB) begin
            idx_o = first3(req_i, IC, ID, IB);
        end else if (last_i == IC) begin
            idx_o = first3(req_i, ID, IB, IC);
        end else begin
            idx_o = first3(req_i, IB, IC, ID);
        end
        if (|req_i) oh_o = 3'b001 << idx_o;
    end

endmodule

// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler driving the shared mux selects and capturing h.
// Winner's one-hot grant is high for the single capture cycle.
import mux8_rr_sched_pkg::*;

module mux8_rr_sched #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       req,
    output logic [2:0]       gnt,
    output logic             s1,
    output logic             s2,
    input  logic [WIDTH-1:0] mux_h,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [2:0]       gnt_q, gnt_d;
    logic [1:0]       win_q, win_d;
    logic [1:0]       last_q, last_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    logic [1:0] pick_idx;
    logic [2:0] pick_oh;

    rr_pick3 u_pick (
        .req_i  (req),
        .last_i (last_q),
        .idx_o  (pick_idx),
        .oh_o   (pick_oh)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= SEL_B;
            gnt_q   <= 3'b000;
            win_q   <= 2'(REQ_B);
            last_q  <= 2'(REQ_D);
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            win_q   <= win_d;
            last_q  <= last_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        win_d   = win_q;
        last_d  = last_q;
        data_d  = data_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    sel_d   = sel_of(pick_idx);
                    gnt_d   = pick_oh;
                    win_d   = pick_idx;
                    state_d = CAPT;
                end
            end
            CAPT: begin
                // selects settled a full cycle ago, so h is stable here
                data_d  = mux_h;
                valid_d = 1'b1;
                gnt_d   = 3'b000;
                last_d  = win_q;
                state_d = HOLD;
            end
            HOLD: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                gnt_d   = 3'b000;
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign gnt       = gnt_q;
    assign s1        = sel_q[0];
    assign s2        = sel_q[1];
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign busy      = (state_q != IDLE);

endmodule
